// File: rtl/sync_release_dispatcher.sv
// Release dispatcher: buffers multicast barrier releases and serialises each
// into per-tile unicasts (ascending tile id) toward the network interface.
package sync_release_pkg;
  typedef struct packed {
    logic [7:0] epoch;
    logic [7:0] barrier_id;
  } sync_release_message_t;
endpackage

module sync_release_dispatcher #(
  parameter int TILE_COUNT = 16,
  parameter int TILE_ID_W  = $clog2(TILE_COUNT),
  parameter int MSG_W      = $bits(sync_release_pkg::sync_release_message_t),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rel_valid,
  input  logic [MSG_W-1:0]      rel_mess,
  input  logic [TILE_COUNT-1:0] rel_dest_mask,
  output logic                  rel_full,
  input  logic                  ni_available,
  output logic                  ni_valid,
  output logic [MSG_W-1:0]      ni_mess,
  output logic [TILE_ID_W-1:0]  ni_dest,
  output logic [TILE_COUNT-1:0] ni_dest_oh,
  output logic                  busy,
  output logic                  overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  logic [FIFO_DEPTH-1:0][MSG_W-1:0]      mem_mess;
  logic [FIFO_DEPTH-1:0][TILE_COUNT-1:0] mem_mask;
  logic [PTR_W-1:0]                      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]                      count;
  logic [MSG_W-1:0]                      cur_mess;
  logic [TILE_COUNT-1:0]                 rem_mask;

  logic                  fifo_empty, fifo_full;
  logic                  accept, drain_done, pop, push;
  logic [TILE_COUNT-1:0] rem_next, head_mask;
  logic [MSG_W-1:0]      head_mess;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign head_mess  = mem_mess[rd_ptr];
  assign head_mask  = mem_mask[rd_ptr];

  // Lowest set bit of the remaining mask selects the current destination.
  always_comb begin
    ni_dest    = '0;
    ni_dest_oh = '0;
    for (int i = TILE_COUNT - 1; i >= 0; i--) begin
      if (rem_mask[i]) begin
        ni_dest    = TILE_ID_W'(i);
        ni_dest_oh = '0;
        ni_dest_oh[i] = 1'b1;
      end
    end
  end

  assign accept     = ni_valid & ni_available;
  assign rem_next   = rem_mask & ~ni_dest_oh;
  assign drain_done = (state == SEND) & accept & (rem_next == '0);
  assign pop        = ~fifo_empty & ((state == IDLE) | drain_done);
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign push       = rel_valid & (~fifo_full | pop);

  assign rel_full = fifo_full;
  assign ni_mess  = cur_mess;
  assign busy     = ~fifo_empty | (state == SEND);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_mess[wr_ptr] <= rel_mess;
      mem_mask[wr_ptr] <= rel_dest_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      ni_valid <= 1'b0;
      cur_mess <= '0;
      rem_mask <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (rel_valid && !push) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            cur_mess <= head_mess;
            rem_mask <= head_mask;
            // Zero-mask releases have no destination and are dropped here.
            if (head_mask != '0) begin
              state    <= SEND;
              ni_valid <= 1'b1;
            end
          end
        end
        SEND: begin
          if (accept) begin
            if (pop) begin
              cur_mess <= head_mess;
              rem_mask <= head_mask;
              if (head_mask == '0) begin
                state    <= IDLE;
                ni_valid <= 1'b0;
              end
            end else begin
              rem_mask <= rem_next;
              if (rem_next == '0) begin
                state    <= IDLE;
                ni_valid <= 1'b0;
              end
            end
          end
        end
        default: begin
          state    <= IDLE;
          ni_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sync_release_dispatcher.sv
// Directed bench for sync_release_dispatcher: latency, backpressure, overflow,
// zero masks, full-with-pop and mid-send reset.
module tb_sync_release_dispatcher;
  logic        clk = 1'b0;
  logic        reset;
  logic        rel_valid;
  logic [15:0] rel_mess;
  logic [15:0] rel_dest_mask;
  logic        rel_full;
  logic        ni_available;
  logic        ni_valid;
  logic [15:0] ni_mess;
  logic [3:0]  ni_dest;
  logic [15:0] ni_dest_oh;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  sync_release_dispatcher dut (
    .clk          (clk),
    .reset        (reset),
    .rel_valid    (rel_valid),
    .rel_mess     (rel_mess),
    .rel_dest_mask(rel_dest_mask),
    .rel_full     (rel_full),
    .ni_available (ni_available),
    .ni_valid     (ni_valid),
    .ni_mess      (ni_mess),
    .ni_dest      (ni_dest),
    .ni_dest_oh   (ni_dest_oh),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [15:0] m, input logic [15:0] mask);
    rel_valid     = 1'b1;
    rel_mess      = m;
    rel_dest_mask = mask;
  endtask

  logic [15:0] exp3_mess [7] = '{16'h10, 16'h10, 16'h11, 16'h12, 16'h13, 16'h13, 16'h14};
  logic [3:0]  exp3_dest [7] = '{4'd0, 4'd2, 4'd1, 4'd15, 4'd4, 4'd5, 4'd0};
  logic [15:0] mask3     [5] = '{16'h0005, 16'h0002, 16'h8000, 16'h0030, 16'h0001};
  logic [15:0] exp5_mess [5] = '{16'h31, 16'h32, 16'h33, 16'h34, 16'h35};
  logic [3:0]  exp5_dest [5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd2};

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; rel_valid = 1'b0; rel_mess = '0; rel_dest_mask = '0; ni_available = 1'b0;
    step(); step();
    chk("rst_valid",    32'(ni_valid),   32'd0);
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_full",     32'(rel_full),   32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    chk("rst_oh",       32'(ni_dest_oh), 32'd0);
    chk("rst_mess",     32'(ni_mess),    32'd0);
    reset = 1'b1;
    step();

    // 1: two-destination release, network always ready
    ni_available = 1'b1;
    push(16'h00A5, 16'h0009); step(); rel_valid = 1'b0;
    chk("t1_valid_t1", 32'(ni_valid), 32'd0);
    chk("t1_busy_t1",  32'(busy),     32'd1);
    step();
    chk("t1_valid_t2", 32'(ni_valid),   32'd1);
    chk("t1_dest_t2",  32'(ni_dest),    32'd0);
    chk("t1_oh_t2",    32'(ni_dest_oh), 32'h1);
    chk("t1_mess_t2",  32'(ni_mess),    32'hA5);
    step();
    chk("t1_valid_t3", 32'(ni_valid),   32'd1);
    chk("t1_dest_t3",  32'(ni_dest),    32'd3);
    chk("t1_oh_t3",    32'(ni_dest_oh), 32'h8);
    step();
    chk("t1_valid_t4", 32'(ni_valid), 32'd0);
    chk("t1_busy_t4",  32'(busy),     32'd0);

    // 2: backpressure holds the offer stable
    ni_available = 1'b0;
    push(16'h00A5, 16'h0009); step(); rel_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(ni_valid), 32'd1);
      chk("t2_hold_dest",  32'(ni_dest),  32'd0);
      chk("t2_hold_mess",  32'(ni_mess),  32'hA5);
      step();
    end
    ni_available = 1'b1;
    chk("t2_dest0", 32'(ni_dest), 32'd0);
    step();
    chk("t2_dest3",  32'(ni_dest),  32'd3);
    chk("t2_valid3", 32'(ni_valid), 32'd1);
    step();
    chk("t2_done", 32'(ni_valid), 32'd0);

    // 3: fill, overflow, then drain in order with no gaps
    ni_available = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(16'h10 + 16'(i), mask3[i]);
      step();
    end
    rel_valid = 1'b0;
    chk("t3_full",    32'(rel_full), 32'd1);
    chk("t3_no_ovf",  32'(overflow), 32'd0);
    push(16'h15, 16'h0001); step(); rel_valid = 1'b0;
    chk("t3_ovf",     32'(overflow), 32'd1);
    chk("t3_full2",   32'(rel_full), 32'd1);
    ni_available = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("t3_valid", 32'(ni_valid), 32'd1);
      chk("t3_mess",  32'(ni_mess),  32'(exp3_mess[i]));
      chk("t3_dest",  32'(ni_dest),  32'(exp3_dest[i]));
      step();
    end
    chk("t3_idle",     32'(ni_valid), 32'd0);
    chk("t3_busy",     32'(busy),     32'd0);
    chk("t3_ovf_hold", 32'(overflow), 32'd1);

    // 4: zero-mask release produces nothing
    push(16'h20, 16'h0000); step();
    chk("t4_zero_valid_a", 32'(ni_valid), 32'd0);
    push(16'h21, 16'h8000); step(); rel_valid = 1'b0;
    chk("t4_zero_valid_b", 32'(ni_valid), 32'd0);
    step();
    chk("t4_valid", 32'(ni_valid),   32'd1);
    chk("t4_dest",  32'(ni_dest),    32'd15);
    chk("t4_oh",    32'(ni_dest_oh), 32'h8000);
    chk("t4_mess",  32'(ni_mess),    32'h21);
    step();
    chk("t4_done", 32'(ni_valid), 32'd0);
    chk("t4_busy", 32'(busy),     32'd0);

    reset = 1'b0; step();
    chk("rst2_ovf", 32'(overflow), 32'd0);
    reset = 1'b1; step();

    // 5: push into a full FIFO in the same cycle as a pop
    ni_available = 1'b0;
    push(16'h30, 16'h0003); step();
    for (int i = 1; i < 5; i++) begin
      push(16'h30 + 16'(i), 16'h0001);
      step();
    end
    rel_valid = 1'b0;
    ni_available = 1'b1;
    chk("t5_full_a", 32'(rel_full), 32'd1);
    chk("t5_dest_a", 32'(ni_dest),  32'd0);
    step();
    chk("t5_full_b", 32'(rel_full), 32'd1);
    chk("t5_dest_b", 32'(ni_dest),  32'd1);
    push(16'h35, 16'h0004); step(); rel_valid = 1'b0;
    chk("t5_full_c", 32'(rel_full), 32'd1);
    chk("t5_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid", 32'(ni_valid), 32'd1);
      chk("t5_mess",  32'(ni_mess),  32'(exp5_mess[i]));
      chk("t5_dest",  32'(ni_dest),  32'(exp5_dest[i]));
      step();
    end
    chk("t5_idle",    32'(ni_valid), 32'd0);
    chk("t5_ovf_end", 32'(overflow), 32'd0);

    // 6: reset in the middle of a broadcast
    push(16'h40, 16'hFFFF); step(); rel_valid = 1'b0;
    step();
    chk("t6_dest0", 32'(ni_dest), 32'd0);
    push(16'h41, 16'h0001); step(); rel_valid = 1'b0;
    chk("t6_dest1", 32'(ni_dest), 32'd1);
    step();
    chk("t6_dest2", 32'(ni_dest), 32'd2);
    step();
    chk("t6_dest3",  32'(ni_dest),  32'd3);
    chk("t6_valid3", 32'(ni_valid), 32'd1);
    reset = 1'b0; step();
    chk("t6_rst_valid", 32'(ni_valid),   32'd0);
    chk("t6_rst_busy",  32'(busy),       32'd0);
    chk("t6_rst_full",  32'(rel_full),   32'd0);
    chk("t6_rst_ovf",   32'(overflow),   32'd0);
    chk("t6_rst_oh",    32'(ni_dest_oh), 32'd0);
    reset = 1'b1; step();
    chk("t6_post_valid", 32'(ni_valid), 32'd0);
    chk("t6_post_busy",  32'(busy),     32'd0);
    step();
    chk("t6_post_valid2", 32'(ni_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
